// File: rtl/banked_window_ram.sv
// Multi-bank RAM returning a rotated window of B consecutive words per read.
// Optional write-first bypass: define BANKED_WINDOW_RAM_BYPASS_EN.
module banked_window_ram #(
  parameter int DW        = 18,
  parameter int LOG_BANKS = 2,
  parameter int LOG_DEPTH = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [LOG_DEPTH-1:0]            wr_addr,
  input  logic [DW-1:0]                   wr_data,
  input  logic                            rd_valid,
  output logic                            rd_ready,
  input  logic [LOG_DEPTH-1:0]            rd_addr,
  output logic                            rd_out_valid,
  output logic [(2**LOG_BANKS)*DW-1:0]    rd_data,
  output logic                            busy
);

  localparam int B  = 1 << LOG_BANKS;
  localparam int RW = LOG_DEPTH - LOG_BANKS;
  localparam int R  = 1 << RW;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t              state_q;
  logic [RW-1:0]       clr_row_q;
  logic                busy_q;

  logic [DW-1:0]       mem_q [B][R];
  logic [DW-1:0]       bank_q [B];
  logic [DW-1:0]       bank_v [B];
  logic [RW-1:0]       rd_row [B];

  logic                s1_vld_q;
  logic [LOG_BANKS-1:0] rot_q;
  logic                out_vld_q;
  logic [B*DW-1:0]     rd_data_q;
  logic [B*DW-1:0]     rd_data_d;

  logic                wr_fire;
  logic                rd_fire;
  logic [LOG_BANKS-1:0] wr_bank;
  logic [RW-1:0]       wr_row;
  logic [LOG_BANKS-1:0] rd_lo;
  logic [RW-1:0]       rd_base_row;

  assign busy         = busy_q;
  assign wr_ready     = ~busy_q;
  assign rd_ready     = ~busy_q;
  assign rd_out_valid = out_vld_q;
  assign rd_data      = rd_data_q;

  assign wr_fire     = wr_valid & ~busy_q;
  assign rd_fire     = rd_valid & ~busy_q;
  assign wr_bank     = wr_addr[LOG_BANKS-1:0];
  assign wr_row      = wr_addr[LOG_DEPTH-1:LOG_BANKS];
  assign rd_lo       = rd_addr[LOG_BANKS-1:0];
  assign rd_base_row = rd_addr[LOG_DEPTH-1:LOG_BANKS];

  // Banks below the base offset hold words from the next row.
  always_comb begin
    for (int b = 0; b < B; b++) begin
      rd_row[b] = rd_base_row + RW'(LOG_BANKS'(b) < rd_lo);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_CLEAR;
      clr_row_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      unique case (state_q)
        S_CLEAR: begin
          clr_row_q <= clr_row_q + 1'b1;
          if (&clr_row_q) begin
            state_q <= S_RUN;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: busy_q <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int b = 0; b < B; b++) begin
        if (state_q == S_CLEAR) begin
          mem_q[b][clr_row_q] <= '0;
        end else if (wr_fire && wr_bank == LOG_BANKS'(b)) begin
          mem_q[b][wr_row] <= wr_data;
        end
        if (rd_fire) begin
          bank_q[b] <= mem_q[b][rd_row[b]];
        end
      end
    end
  end

`ifdef BANKED_WINDOW_RAM_BYPASS_EN
  logic [B-1:0]  byp_q;
  logic [DW-1:0] byp_data_q;

  always_ff @(posedge clk) begin
    if (rd_fire) begin
      byp_data_q <= wr_data;
      for (int b = 0; b < B; b++) begin
        byp_q[b] <= wr_fire &&
                    (wr_addr == {rd_row[b], LOG_BANKS'(b)});
      end
    end
  end

  always_comb begin
    for (int b = 0; b < B; b++) begin
      bank_v[b] = byp_q[b] ? byp_data_q : bank_q[b];
    end
  end
`else
  always_comb begin
    for (int b = 0; b < B; b++) begin
      bank_v[b] = bank_q[b];
    end
  end
`endif

  always_comb begin
    rd_data_d = '0;
    for (int k = 0; k < B; k++) begin
      rd_data_d[k*DW +: DW] = bank_v[rot_q + LOG_BANKS'(k)];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      rot_q     <= '0;
      out_vld_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      s1_vld_q  <= rd_fire;
      out_vld_q <= s1_vld_q;
      if (rd_fire) begin
        rot_q <= rd_lo;
      end
      if (s1_vld_q) begin
        rd_data_q <= rd_data_d;
      end
    end
  end

endmodule
